minesweeper_ctrl_fsm: RTL

Parametrised top-level game controller for the minesweeper datapath, on a single clock. Sequences mine placement, command load/decode, ALU evaluation and board display, as the first-generation controller does. Adds the following:
- board-size parameters
- a safe-cell countdown with win detection
- a reveal/flag command mode
- a saturating move counter
- an optional watchdog on handshake waits

---
 rtl/minesweeper_ctrl_fsm_if.sv | 52 +++++
 rtl/minesweeper_ctrl_fsm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/minesweeper_ctrl_fsm_if.sv
// Handshake / status bundle between the minesweeper game controller and
// its datapath.
//   master : the controller. It samples the datapath/user request lines
//            (place, place_done, data_in/data, alu_done/alu_reveals/gameover,
//            display_done) and drives state, the one-cycle strobes
//            (start, load, decode, alu, display) and game status
//            (flag_mode, win, lose, move_count, safe_left, timeout_err).
//   slave  : the datapath / user side, with the directions reversed.
// Handshake rule: a wait state consumes its request only on a clock edge
// where every qualifying input is high together (e.g. display_done &
// data_in). Requests seen in any other state are ignored and not remembered.
interface minesweeper_ctrl_fsm_if #(
  parameter int DATA_W = 7,
  parameter int CELL_W = 7,
  parameter int MOVE_W = 8
) ();
  logic              place;
  logic              place_done;
  logic              data_in;
  logic [DATA_W-1:0] data;
  logic              alu_done;
  logic [CELL_W-1:0] alu_reveals;
  logic              gameover;
  logic              display_done;

  logic [3:0]        state;
  logic              start;
  logic              load;
  logic              decode;
  logic              alu;
  logic              display;
  logic              flag_mode;
  logic              win;
  logic              lose;
  logic [MOVE_W-1:0] move_count;
  logic [CELL_W-1:0] safe_left;
  logic              timeout_err;

  modport master (
    input  place, place_done, data_in, data, alu_done, alu_reveals,
           gameover, display_done,
    output state, start, load, decode, alu, display, flag_mode, win, lose,
           move_count, safe_left, timeout_err
  );

  modport slave (
    output place, place_done, data_in, data, alu_done, alu_reveals,
           gameover, display_done,
    input  state, start, load, decode, alu, display, flag_mode, win, lose,
           move_count, safe_left, timeout_err
  );
endinterface

// File: rtl/minesweeper_ctrl_fsm.sv
// Minesweeper game controller. Sequences mine placement, command load,
// decode, ALU evaluation and board display, tracks the number of unrevealed
// safe cells (win when it reaches zero on a reveal), the move count
// (saturating) and the reveal/flag mode of the current command.
// Ports:
//   clka    : clock, all logic on posedge
//   restart : synchronous active-high reset, overrides everything
//   bus     : minesweeper_ctrl_fsm_if.master (requests in, strobes/status out)
// Optional build macro WATCHDOG_EN: bounds each handshake wait to TIMEOUT
// cycles; on expiry the FSM returns to IDLE and timeout_err is set (sticky
// until restart or the next game). Without it waits are unbounded and
// timeout_err is tied low.
// All outputs come straight from registers.
module minesweeper_ctrl_fsm #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int MINES   = 10,
  parameter int DATA_W  = 7,
  parameter int CELL_W  = 7,
  parameter int MOVE_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input logic                   clka,
  input logic                   restart,
  minesweeper_ctrl_fsm_if.master bus
);
  localparam logic [CELL_W-1:0] SAFE_INIT = CELL_W'(ROWS * COLS - MINES);
  localparam logic [MOVE_W-1:0] MOVE_MAX  = '1;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_PLACE        = 4'd1,
    S_PLACE_WAIT   = 4'd2,
    S_LOAD         = 4'd3,
    S_DECODE       = 4'd4,
    S_ALU          = 4'd5,
    S_ALU_WAIT     = 4'd6,
    S_DISPLAY      = 4'd7,
    S_DISPLAY_WAIT = 4'd8,
    S_GAMEOVER     = 4'd9,
    S_WIN          = 4'd10
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        strobe_q, strobe_d;  // {start, load, decode, alu, display}
  logic              flag_q, flag_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;
  logic [MOVE_W-1:0] move_q, move_d;
  logic [CELL_W-1:0] safe_q, safe_d;
  logic [CELL_W-1:0] safe_sub;
  logic              wd_expired;

  always_comb begin
    state_d  = state_q;
    flag_d   = flag_q;
    win_d    = win_q;
    lose_d   = lose_q;
    move_d   = move_q;
    safe_d   = safe_q;
    // Remaining safe cells after this reveal, floored at zero.
    safe_sub = (bus.alu_reveals >= safe_q) ? '0 : safe_q - bus.alu_reveals;

    case (state_q)
      S_IDLE: begin
        if (bus.place) begin
          state_d = S_PLACE;
          move_d  = '0;
          safe_d  = SAFE_INIT;
          win_d   = 1'b0;
          lose_d  = 1'b0;
        end
      end
      S_PLACE: state_d = S_PLACE_WAIT;
      S_PLACE_WAIT, S_DISPLAY_WAIT: begin
        if ((state_q == S_PLACE_WAIT ? bus.place_done : bus.display_done) && bus.data_in) begin
          state_d = S_LOAD;
          flag_d  = bus.data[DATA_W-1];
          if (move_q != MOVE_MAX) move_d = move_q + 1'b1;
        end else if (wd_expired) begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:   state_d = S_DECODE;
      S_DECODE: state_d = S_ALU;
      S_ALU:    state_d = S_ALU_WAIT;
      S_ALU_WAIT: begin
        if (bus.alu_done) begin
          if (!flag_q) safe_d = safe_sub;
          // A mine hit outranks a simultaneous clearing reveal.
          if (bus.gameover) begin
            state_d = S_GAMEOVER;
            lose_d  = 1'b1;
          end else if (!flag_q && (safe_sub == '0)) begin
            state_d = S_WIN;
            win_d   = 1'b1;
          end else begin
            state_d = S_DISPLAY;
          end
        end else if (wd_expired) begin
          state_d = S_IDLE;
        end
      end
      S_DISPLAY: state_d = S_DISPLAY_WAIT;
      S_GAMEOVER, S_WIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes follow the next state so each is high exactly while the
    // state register holds its owning state.
    strobe_d = {state_d == S_PLACE, state_d == S_LOAD, state_d == S_DECODE,
                state_d == S_ALU, state_d == S_DISPLAY};
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q  <= S_IDLE;
      strobe_q <= '0;
      flag_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      move_q   <= '0;
      safe_q   <= SAFE_INIT;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      flag_q   <= flag_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      move_q   <= move_d;
      safe_q   <= safe_d;
    end
  end

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            in_wait;
  logic            terr_q;

  assign in_wait = (state_q == S_PLACE_WAIT) || (state_q == S_ALU_WAIT) ||
                   (state_q == S_DISPLAY_WAIT);
  // Wait states are only entered from non-wait states, so holding the
  // counter at zero outside them clears it on every entry.
  assign wd_expired = in_wait && (wd_q >= WD_W'(TIMEOUT - 1));

  always_ff @(posedge clka) begin
    if (restart || !in_wait) wd_q <= '0;
    else                     wd_q <= wd_q + WD_W'(1);
  end

  always_ff @(posedge clka) begin
    if (restart)                                 terr_q <= 1'b0;
    else if (state_d == S_PLACE)                 terr_q <= 1'b0;
    else if (wd_expired && (state_d == S_IDLE))  terr_q <= 1'b1;
  end

  assign bus.timeout_err = terr_q;
`else
  logic wd_unused;
  assign wd_unused       = ^TIMEOUT;
  assign wd_expired      = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.state      = state_q;
  assign bus.start      = strobe_q[4];
  assign bus.load       = strobe_q[3];
  assign bus.decode     = strobe_q[2];
  assign bus.alu        = strobe_q[1];
  assign bus.display    = strobe_q[0];
  assign bus.flag_mode  = flag_q;
  assign bus.win        = win_q;
  assign bus.lose       = lose_q;
  assign bus.move_count = move_q;
  assign bus.safe_left  = safe_q;
endmodule
